// File: rtl/srl_fifo_pkg.sv
// Shared definitions for the SRL-based FIFO controller.
//   state_t       : occupancy state of the SRL column (empty / partial / full)
//   SRL_MAX_DEPTH : number of taps in one SRL primitive
//   SRL_ADDR_W    : read tap address width
//   CNT_W         : occupancy counter width (holds up to 17 with the output stage)
package srl_fifo_pkg;

    localparam int unsigned SRL_MAX_DEPTH = 16;
    localparam int unsigned SRL_ADDR_W    = 4;
    localparam int unsigned CNT_W         = 5;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PART,
        S_FULL
    } state_t;

endpackage

// File: rtl/srl_fifo_ctrl_if.sv
// Streaming bus of the SRL FIFO: producer-side and consumer-side valid/ready
// handshakes plus occupancy status.
//   slave  : FIFO side (accepts in_*, presents out_* and status)
//   master : environment side (producer + consumer)
interface srl_fifo_ctrl_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic [WIDTH-1:0]                 in_data;
    logic                             in_valid;
    logic                             in_ready;
    logic [WIDTH-1:0]                 out_data;
    logic                             out_valid;
    logic                             out_ready;
    logic [srl_fifo_pkg::CNT_W-1:0]   count;
    logic                             full;
    logic                             empty;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, count, full, empty
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, count, full, empty
    );

endinterface

// File: rtl/srl16_shreg.sv
// WIDTH-wide, 16-tap addressable shift register; one SRLC16E-style column per
// data bit. Tap 0 holds the newest entry. No reset: the primitive has none.
//   clk  : clock, rising edge
//   ce   : shift enable; inserts d at tap 0 and moves every entry up one tap
//   addr : read tap select
//   d    : shift-in data
//   q    : contents of tap addr (combinational)
module srl16_shreg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             ce,
    input  logic [3:0]       addr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] taps [16];

    always_ff @(posedge clk) begin
        if (ce) begin
            taps[0] <= d;
            for (int unsigned i = 1; i < 16; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign q = taps[addr];

endmodule

// File: rtl/srl_fifo_ctrl.sv
// First-word fall-through FIFO built on an addressable SRL column. The
// controller owns the shift enable (every accepted write shifts) and the read
// tap address, which tracks the oldest entry at tap count-1.
//   CLK   : clock, rising edge
//   RST_N : asynchronous active-low reset (SRL contents are not reset)
//   bus   : slave side of srl_fifo_ctrl_if (handshakes, data, count/full/empty)
// Optional macro SRL_FIFO_OUTREG_EN: adds a one-entry registered output stage
// behind the SRL tap (capacity DEPTH+1, empty-to-valid latency 2). Without it
// the tap drives out_data combinationally (latency 1).
module srl_fifo_ctrl
    import srl_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    srl_fifo_ctrl_if.slave   bus
);

    if (DEPTH < 2 || DEPTH > SRL_MAX_DEPTH) begin : g_bad_depth
        $error("srl_fifo_ctrl: DEPTH must lie in 2..16");
    end

    state_t                state;
    logic [CNT_W-1:0]      srl_cnt;
    logic [SRL_ADDR_W-1:0] addr;
    logic                  rdy_en;
    logic                  push;
    logic                  srl_pop;
    logic                  srl_valid;
    logic [WIDTH-1:0]      tap;

    assign srl_valid   = (state != S_EMPTY);
    // rdy_en holds off writes for the first cycle after reset release
    assign bus.in_ready = rdy_en & (state != S_FULL);
    assign push         = bus.in_valid & bus.in_ready;

    srl16_shreg #(
        .WIDTH (WIDTH)
    ) u_srl (
        .clk  (CLK),
        .ce   (push),
        .addr (addr),
        .d    (bus.in_data),
        .q    (tap)
    );

    // addr always equals srl_cnt-1 while non-empty. On push+pop the shift moves
    // the next-oldest entry onto the current tap, so nothing changes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= S_EMPTY;
            srl_cnt <= '0;
            addr    <= '0;
            rdy_en  <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            case ({push, srl_pop})
                2'b10: begin
                    srl_cnt <= srl_cnt + CNT_W'(1);
                    if (state != S_EMPTY) begin
                        addr <= addr + SRL_ADDR_W'(1);
                    end
                    state <= (srl_cnt == CNT_W'(DEPTH - 1)) ? S_FULL : S_PART;
                end
                2'b01: begin
                    srl_cnt <= srl_cnt - CNT_W'(1);
                    if (srl_cnt == CNT_W'(1)) begin
                        addr  <= '0;
                        state <= S_EMPTY;
                    end else begin
                        addr  <= addr - SRL_ADDR_W'(1);
                        state <= S_PART;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SRL_FIFO_OUTREG_EN
    logic             stage_valid;
    logic [WIDTH-1:0] stage_data;
    logic [CNT_W-1:0] total_cnt;

    // The stage refills whenever it is empty or being drained this cycle.
    assign srl_pop = srl_valid & (~stage_valid | bus.out_ready);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stage_valid <= 1'b0;
        end else if (srl_pop) begin
            stage_valid <= 1'b1;
        end else if (bus.out_ready) begin
            stage_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (srl_pop) begin
            stage_data <= tap;
        end
    end

    assign total_cnt     = srl_cnt + CNT_W'(stage_valid);
    assign bus.out_valid = stage_valid;
    assign bus.out_data  = stage_data;
    assign bus.count     = total_cnt;
    assign bus.full      = (total_cnt == CNT_W'(DEPTH + 1));
    assign bus.empty     = (total_cnt == '0);
`else
    assign srl_pop       = srl_valid & bus.out_ready;
    assign bus.out_valid = srl_valid;
    assign bus.out_data  = tap;
    assign bus.count     = srl_cnt;
    assign bus.full      = (state == S_FULL);
    assign bus.empty     = (state == S_EMPTY);
`endif

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Self-checking bench for srl_fifo_ctrl: directed steps plus a randomized phase,
// each cycle compared against a queue model of the FIFO. Also builds with
// SRL_FIFO_OUTREG_EN defined (capacity and latency follow the macro).
module tb_srl_fifo_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;
`ifdef SRL_FIFO_OUTREG_EN
    localparam int unsigned CAP = DEPTH + 1;
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned CAP = DEPTH;
    localparam int unsigned LAT = 1;
`endif

    typedef struct {
        logic [WIDTH-1:0] d;
        int unsigned      b;
    } ent_t;

    logic clk;
    logic rst_n;
    int unsigned n_checks;
    int unsigned n_fails;
    int unsigned ncyc;
    logic        rdy_m;
    ent_t        q[$];

    srl_fifo_ctrl_if #(.WIDTH(WIDTH)) bus ();

    srl_fifo_ctrl #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs follow from the queue: the head is visible once it has
    // been stored for LAT-1 clock edges; writes are accepted below capacity.
    task automatic check_outputs(input string tag, output logic er, output logic ev);
        int unsigned sz;
        sz = q.size();
        er = rdy_m && (sz < CAP);
        ev = (sz > 0) ? ((ncyc - q[0].b) >= (LAT - 1)) : 1'b0;
        chk({tag, ".in_ready"},  bus.in_ready,  er);
        chk({tag, ".out_valid"}, bus.out_valid, ev);
        chk({tag, ".count"},     bus.count,     sz);
        chk({tag, ".full"},      bus.full,      sz == CAP);
        chk({tag, ".empty"},     bus.empty,     sz == 0);
        if (ev) chk({tag, ".out_data"}, bus.out_data, q[0].d);
    endtask

    task automatic cycle(input string tag, input logic v, input logic [WIDTH-1:0] d,
                         input logic r);
        logic er, ev;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        check_outputs(tag, er, ev);
        @(posedge clk);
        #1;
        ncyc++;
        if (ev && r) void'(q.pop_front());
        if (er && v) q.push_back('{d: d, b: ncyc});
        rdy_m = 1'b1;
    endtask

    task automatic model_reset();
        q.delete();
        rdy_m = 1'b0;
    endtask

    initial begin
        logic er, ev;
        n_checks = 0;
        n_fails  = 0;
        ncyc     = 0;
        model_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;

        // Reset values, then release between edges
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset", er, ev);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        // First cycle after release: offered word must be refused
        cycle("rel0", 1'b1, 8'h77, 1'b0);
        cycle("rel1", 1'b0, 8'h00, 1'b0);

        // Fill to capacity with the consumer stalled
        for (int unsigned i = 1; i <= CAP; i++) begin
            cycle("fill", 1'b1, WIDTH'(i), 1'b0);
        end
        cycle("full_hold", 1'b1, 8'hEE, 1'b0);

        // Full with offer and pop together: pop only, then offer accepted
        cycle("full_pp", 1'b1, 8'hEE, 1'b1);
        cycle("full_pp_next", 1'b1, 8'hEE, 1'b0);

        // Drain completely
        for (int unsigned k = 0; k < CAP + 4 && q.size() > 0; k++) begin
            cycle("drain", 1'b0, 8'h00, 1'b1);
        end
        cycle("drained", 1'b0, 8'h00, 1'b0);

        // Pop on empty has no effect
        cycle("empty_pop", 1'b0, 8'h00, 1'b1);
        cycle("empty_pop2", 1'b0, 8'h00, 1'b1);

        // Occupancy 5 with simultaneous push/pop streaming through
        for (int unsigned i = 0; i < 5; i++) begin
            cycle("sim_fill", 1'b1, WIDTH'(8'hA0 + i), 1'b0);
        end
        for (int unsigned i = 0; i < 8; i++) begin
            cycle("sim_pp", 1'b1, WIDTH'(8'hB0 + i), 1'b1);
        end
        for (int unsigned k = 0; k < CAP + 4 && q.size() > 0; k++) begin
            cycle("sim_drain", 1'b0, 8'h00, 1'b1);
        end

        // Randomized traffic: first write-biased, then read-biased
        for (int unsigned i = 0; i < 400; i++) begin
            logic v, r;
            if (i < 200) begin
                v = ($urandom_range(3) != 0);
                r = ($urandom_range(3) == 0);
            end else begin
                v = ($urandom_range(3) == 0);
                r = ($urandom_range(3) != 0);
            end
            cycle("rand", v, WIDTH'($urandom), r);
        end
        for (int unsigned k = 0; k < CAP + 4 && q.size() > 0; k++) begin
            cycle("rand_drain", 1'b0, 8'h00, 1'b1);
        end

        // Mid-operation asynchronous reset at occupancy 7
        for (int unsigned i = 0; i < 7; i++) begin
            cycle("pre_rst", 1'b1, WIDTH'(8'hC0 + i), 1'b0);
        end
        cycle("pre_rst_hold", 1'b0, 8'h00, 1'b0);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst", er, ev);
        #2;
        rst_n = 1'b1;
        cycle("post_rst0", 1'b0, 8'h00, 1'b0);
        cycle("post_rst_push", 1'b1, 8'h5A, 1'b0);
        for (int unsigned k = 0; k < 4 && q.size() > 0; k++) begin
            cycle("post_rst_read", 1'b0, 8'h00, 1'b1);
        end
        cycle("final", 1'b0, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
